a2d_sched: RTL and testbench



---
 rtl/a2d_sched_if.sv | 16 +
 rtl/a2d_sched.sv | 191 +++++++++++++++++++
 tb/tb_a2d_sched.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/a2d_sched_if.sv
// a2d_sched_if
// Handshake bundle between the A2D scheduler and the shared A2D SPI front end.
//   strt_cnv  : 1-cycle start-conversion pulse (scheduler -> A2D)
//   chnnl     : 3-bit channel select, held from strt_cnv until cnv_cmplt
//   cnv_cmplt : 1-cycle conversion-done pulse (A2D -> scheduler)
//   res       : 12-bit conversion result, valid while cnv_cmplt is high
// Modports: master = scheduler side, slave = converter side.
interface a2d_sched_if;
   logic        strt_cnv;
   logic [2:0]  chnnl;
   logic        cnv_cmplt;
   logic [11:0] res;

   modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
   modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);
endinterface

// File: rtl/a2d_sched.sv
// a2d_sched
// Round-robin scheduler for the single shared A2D converter. While go is
// high it enables the IR emitters, waits out a settle window, then sweeps
// IR channels 0..NUM_IR-1 continuously, writing every result into the
// sensor register file. A battery conversion on channel 7 is slipped in
// after every BATT_PERIOD completed sweeps and refreshes the batt_low flag.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   go         : movement enable from the command controller
//   a2d        : converter handshake (strt_cnv/chnnl out, cnv_cmplt/res in)
//   IR_en      : IR emitter enable (high in every state but IDLE)
//   ir_wr      : 1-cycle write strobe, with ir_idx / ir_data
//   sweep_done : 1-cycle pulse alongside the write of the last IR channel
//   batt_low   : battery below BATT_THRESH, rewritten on each battery read
// All outputs are registered.
module a2d_sched #(
   parameter int          NUM_IR        = 6,
   parameter int          SETTLE_CYCLES = 4096,
   parameter int          BATT_PERIOD   = 16,
   parameter logic [11:0] BATT_THRESH   = 12'hA98
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   a2d_sched_if.master       a2d,
   output logic              IR_en,
   output logic              ir_wr,
   output logic [2:0]        ir_idx,
   output logic [11:0]       ir_data,
   output logic              sweep_done,
   output logic              batt_low
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int BW = $clog2(BATT_PERIOD + 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [BW-1:0] BATT_LAST   = BW'(BATT_PERIOD - 1);
   localparam logic [2:0]    LAST_IDX    = 3'(NUM_IR - 1);
   localparam logic [2:0]    BATT_CHNNL  = 3'd7;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      CONV   = 3'd2,
      WAIT   = 3'd3,
      BCONV  = 3'd4,
      BWAIT  = 3'd5
   } state_t;

   state_t         state_q, state_d;
   logic [SW-1:0]  settle_cnt_q, settle_cnt_d;
   logic [BW-1:0]  sweep_cnt_q, sweep_cnt_d;
   logic [2:0]     idx_q, idx_d;
   logic           strt_cnv_q, strt_cnv_d;
   logic [2:0]     chnnl_q, chnnl_d;
   logic           ir_en_q, ir_en_d;
   logic           ir_wr_q, ir_wr_d;
   logic [2:0]     ir_idx_q, ir_idx_d;
   logic [11:0]    ir_data_q, ir_data_d;
   logic           sweep_done_q, sweep_done_d;
   logic           batt_low_q, batt_low_d;

   // Next-state and next-output logic. Every output is computed here one
   // cycle ahead and registered below, so a decision taken at edge N shows
   // up on the outputs in cycle N+1. The first conversion of a run is
   // launched straight out of SETTLE (idx 0, channel 0) so that strt_cnv
   // lands in the cycle right after the settle window; later conversions
   // pass through CONV, which leaves one cycle for the ir_wr strobe before
   // the next strt_cnv. chnnl only changes when a conversion is launched,
   // which keeps it stable until the matching cnv_cmplt. cnv_cmplt is only
   // looked at in WAIT/BWAIT, so stray completions elsewhere do nothing.
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      sweep_cnt_d  = sweep_cnt_q;
      idx_d        = idx_q;
      strt_cnv_d   = 1'b0;
      chnnl_d      = chnnl_q;
      ir_wr_d      = 1'b0;
      ir_idx_d     = ir_idx_q;
      ir_data_d    = ir_data_q;
      sweep_done_d = 1'b0;
      batt_low_d   = batt_low_q;

      case (state_q)
         IDLE: begin
            if (go) begin
               state_d      = SETTLE;
               settle_cnt_d = '0;
            end
         end
         SETTLE: begin
            if (!go) begin
               state_d = IDLE;
            end else if (settle_cnt_q == SETTLE_LAST) begin
               idx_d      = 3'd0;
               strt_cnv_d = 1'b1;
               chnnl_d    = 3'd0;
               state_d    = WAIT;
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end
         end
         CONV: begin
            strt_cnv_d = 1'b1;
            chnnl_d    = idx_q;
            state_d    = WAIT;
         end
         WAIT: begin
            if (a2d.cnv_cmplt) begin
               ir_wr_d   = 1'b1;
               ir_idx_d  = idx_q;
               ir_data_d = a2d.res;
               if (idx_q < LAST_IDX) begin
                  idx_d   = idx_q + 3'd1;
                  state_d = CONV;
               end else begin
                  sweep_done_d = 1'b1;
                  idx_d        = 3'd0;
                  if (sweep_cnt_q == BATT_LAST) begin
                     sweep_cnt_d = '0;
                     state_d     = BCONV;
                  end else begin
                     sweep_cnt_d = sweep_cnt_q + 1'b1;
                     state_d     = go ? CONV : IDLE;
                  end
               end
            end
         end
         BCONV: begin
            strt_cnv_d = 1'b1;
            chnnl_d    = BATT_CHNNL;
            state_d    = BWAIT;
         end
         BWAIT: begin
            if (a2d.cnv_cmplt) begin
               batt_low_d = (a2d.res < BATT_THRESH);
               idx_d      = 3'd0;
               state_d    = go ? CONV : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ir_en_d = (state_d != IDLE);
   end

   // State and output registers. Reset drops everything back to IDLE with
   // all outputs low, which also abandons any conversion in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         settle_cnt_q <= '0;
         sweep_cnt_q  <= '0;
         idx_q        <= '0;
         strt_cnv_q   <= 1'b0;
         chnnl_q      <= '0;
         ir_en_q      <= 1'b0;
         ir_wr_q      <= 1'b0;
         ir_idx_q     <= '0;
         ir_data_q    <= '0;
         sweep_done_q <= 1'b0;
         batt_low_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         sweep_cnt_q  <= sweep_cnt_d;
         idx_q        <= idx_d;
         strt_cnv_q   <= strt_cnv_d;
         chnnl_q      <= chnnl_d;
         ir_en_q      <= ir_en_d;
         ir_wr_q      <= ir_wr_d;
         ir_idx_q     <= ir_idx_d;
         ir_data_q    <= ir_data_d;
         sweep_done_q <= sweep_done_d;
         batt_low_q   <= batt_low_d;
      end
   end

   assign a2d.strt_cnv = strt_cnv_q;
   assign a2d.chnnl    = chnnl_q;
   assign IR_en        = ir_en_q;
   assign ir_wr        = ir_wr_q;
   assign ir_idx       = ir_idx_q;
   assign ir_data      = ir_data_q;
   assign sweep_done   = sweep_done_q;
   assign batt_low     = batt_low_q;

endmodule

// File: tb/tb_a2d_sched.sv
// tb_a2d_sched
// Directed bench for a2d_sched with SETTLE_CYCLES=8, NUM_IR=6,
// BATT_PERIOD=2. A behavioural A2D answers every strt_cnv 20 cycles later
// with res = 12'h100 + chnnl for IR channels and batt_res for channel 7.
// A monitor logs every strt_cnv and ir_wr with its cycle number; the main
// sequence walks through settle latency, sweep order, battery interleave,
// go dropped mid-sweep, a short go pulse and reset during a conversion.
module tb_a2d_sched;

   logic        clk;
   logic        rst;
   logic        go;
   logic        ir_en;
   logic        ir_wr;
   logic [2:0]  ir_idx;
   logic [11:0] ir_data;
   logic        sweep_done;
   logic        batt_low;
   logic [11:0] batt_res;

   int errors;
   int checks;
   int cyc;

   int          strt_n;
   int          wr_n;
   logic [2:0]  strt_ch   [64];
   int          strt_cyc  [64];
   logic [2:0]  wr_idx    [64];
   logic [11:0] wr_data   [64];
   logic        wr_sd     [64];
   int          wr_cyc    [64];
   int          strt_dbl;
   int          wr_dbl;
   int          sd_orphan;

   a2d_sched_if a2d ();

   a2d_sched #(
      .NUM_IR       (6),
      .SETTLE_CYCLES(8),
      .BATT_PERIOD  (2),
      .BATT_THRESH  (12'hA98)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .go        (go),
      .a2d       (a2d.master),
      .IR_en     (ir_en),
      .ir_wr     (ir_wr),
      .ir_idx    (ir_idx),
      .ir_data   (ir_data),
      .sweep_done(sweep_done),
      .batt_low  (batt_low)
   );

   // 10-time-unit clock and a free-running cycle counter for latency checks.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   // Behavioural converter: sees strt_cnv at the falling edge, answers with a
   // one-cycle cnv_cmplt 20 cycles later, keeps running straight through reset.
   initial begin
      logic [2:0] ch;
      a2d.cnv_cmplt = 1'b0;
      a2d.res       = 12'h000;
      forever begin
         @(negedge clk);
         if (a2d.strt_cnv === 1'b1) begin
            ch = a2d.chnnl;
            repeat (20) @(negedge clk);
            a2d.res       = (ch == 3'd7) ? batt_res : (12'h100 + {9'd0, ch});
            a2d.cnv_cmplt = 1'b1;
            @(negedge clk);
            a2d.cnv_cmplt = 1'b0;
         end
      end
   end

   // Transaction log of launches and writes, plus pulse-width and
   // sweep_done-without-write bookkeeping.
   initial begin
      logic prev_strt;
      logic prev_wr;
      strt_n = 0; wr_n = 0; strt_dbl = 0; wr_dbl = 0; sd_orphan = 0;
      prev_strt = 1'b0; prev_wr = 1'b0;
      forever begin
         @(negedge clk);
         if (a2d.strt_cnv === 1'b1) begin
            if (strt_n < 64) begin
               strt_ch[strt_n]  = a2d.chnnl;
               strt_cyc[strt_n] = cyc;
            end
            strt_n = strt_n + 1;
            if (prev_strt) strt_dbl = strt_dbl + 1;
         end
         if (ir_wr === 1'b1) begin
            if (wr_n < 64) begin
               wr_idx[wr_n]  = ir_idx;
               wr_data[wr_n] = ir_data;
               wr_sd[wr_n]   = sweep_done;
               wr_cyc[wr_n]  = cyc;
            end
            wr_n = wr_n + 1;
            if (prev_wr) wr_dbl = wr_dbl + 1;
         end
         if (sweep_done === 1'b1 && ir_wr !== 1'b1) sd_orphan = sd_orphan + 1;
         prev_strt = (a2d.strt_cnv === 1'b1);
         prev_wr   = (ir_wr === 1'b1);
      end
   end

   // Hard stop in case something upstream never returns.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks = checks + 1;
      assert (observed === expected) else begin
         errors = errors + 1;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic g, input logic r, input int n);
      go  = g;
      rst = r;
      repeat (n) @(negedge clk);
   endtask

   task automatic waitFor(input string tag, input int target, input bit use_wr);
      for (int i = 0; i < 3000; i++) begin
         if ((use_wr ? wr_n : strt_n) >= target) break;
         @(negedge clk);
      end
      checkOutput(tag, 32'((use_wr ? wr_n : strt_n) >= target), 32'd1);
   endtask

   // Raise go at a falling edge (next rising edge is edge 0) and check that
   // IR_en rises in cycle 1 and the only strt_cnv of the window is in cycle 9.
   task automatic settleCheck(input string tag);
      int early;
      early = 0;
      go = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (c == 1) checkOutput({tag, "_ir_en_c1"}, 32'(ir_en), 32'd1);
         if (c < 9 && a2d.strt_cnv === 1'b1) early = early + 1;
         if (c == 9) begin
            checkOutput({tag, "_strt_c9"}, 32'(a2d.strt_cnv), 32'd1);
            checkOutput({tag, "_chnnl_c9"}, 32'(a2d.chnnl), 32'd0);
         end
      end
      checkOutput({tag, "_early_strt"}, 32'(early), 32'd0);
   endtask

   // Directed sequence.
   initial begin
      errors   = 0;
      checks   = 0;
      batt_res = 12'hA00;
      rst      = 1'b1;
      go       = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_ir_en",      32'(ir_en),        32'd0);
      checkOutput("rst_strt",       32'(a2d.strt_cnv), 32'd0);
      checkOutput("rst_chnnl",      32'(a2d.chnnl),    32'd0);
      checkOutput("rst_ir_wr",      32'(ir_wr),        32'd0);
      checkOutput("rst_sweep_done", 32'(sweep_done),   32'd0);
      checkOutput("rst_batt_low",   32'(batt_low),     32'd0);
      applyStimulus(1'b0, 1'b0, 2);

      // Settle latency
      settleCheck("settle1");

      // Sweep order, data and handshake latency
      waitFor("wait_sweep1", 6, 1'b1);
      for (int k = 0; k < 6; k++) begin
         checkOutput($sformatf("wr_idx[%0d]", k),  32'(wr_idx[k]),  32'(k));
         checkOutput($sformatf("wr_data[%0d]", k), 32'(wr_data[k]), 32'(12'h100 + k));
         checkOutput($sformatf("wr_sd[%0d]", k),   32'(wr_sd[k]),   32'(k == 5));
         checkOutput($sformatf("strt_ch[%0d]", k), 32'(strt_ch[k]), 32'(k));
      end
      checkOutput("cmplt_to_wr", 32'(wr_cyc[0] - strt_cyc[0]), 32'd21);
      checkOutput("wr_to_strt",  32'(strt_cyc[1] - wr_cyc[0]), 32'd1);

      // Battery interleave: first read below threshold
      waitFor("wait_batt1_next", 14, 1'b0);
      checkOutput("batt1_chnnl",    32'(strt_ch[12]), 32'd7);
      checkOutput("batt1_after_ch", 32'(strt_ch[13]), 32'd0);
      checkOutput("batt1_launch",   32'(strt_cyc[12] - wr_cyc[11]), 32'd1);
      checkOutput("batt1_no_wr",    32'(wr_n), 32'd12);
      checkOutput("batt1_low",      32'(batt_low), 32'd1);
      for (int k = 6; k < 12; k++) begin
         checkOutput($sformatf("wr_sd[%0d]", k), 32'(wr_sd[k]), 32'(k == 11));
      end
      batt_res = 12'hB00;

      // Second battery read above threshold clears the flag
      waitFor("wait_batt2_next", 27, 1'b0);
      checkOutput("batt2_chnnl",    32'(strt_ch[25]), 32'd7);
      checkOutput("batt2_low",      32'(batt_low), 32'd0);
      checkOutput("batt2_no_wr",    32'(wr_n), 32'd24);
      checkOutput("sweep3_idx0",    32'(wr_idx[12]), 32'd0);

      // go dropped while idx 2 is converting
      waitFor("wait_idx2", 29, 1'b0);
      go = 1'b0;
      waitFor("wait_sweep5", 30, 1'b1);
      repeat (3) @(negedge clk);
      checkOutput("drop_idx3",     32'(wr_idx[27]), 32'd3);
      checkOutput("drop_idx5",     32'(wr_idx[29]), 32'd5);
      checkOutput("drop_data5",    32'(wr_data[29]), 32'h105);
      checkOutput("drop_ir_en",    32'(ir_en), 32'd0);
      checkOutput("drop_strt_cnt", 32'(strt_n), 32'd32);
      checkOutput("drop_wr_cnt",   32'(wr_n), 32'd30);
      settleCheck("settle2");

      // Reset while the idx 0 conversion is in flight; its completion arrives late
      applyStimulus(1'b1, 1'b0, 2);
      applyStimulus(1'b0, 1'b1, 2);
      applyStimulus(1'b0, 1'b0, 30);
      checkOutput("rstw_wr_cnt",     32'(wr_n), 32'd30);
      checkOutput("rstw_strt_cnt",   32'(strt_n), 32'd33);
      checkOutput("rstw_ir_en",      32'(ir_en), 32'd0);
      checkOutput("rstw_strt",       32'(a2d.strt_cnv), 32'd0);
      checkOutput("rstw_ir_wr",      32'(ir_wr), 32'd0);
      checkOutput("rstw_chnnl",      32'(a2d.chnnl), 32'd0);
      checkOutput("rstw_batt_low",   32'(batt_low), 32'd0);

      // Short go pulse inside the settle window
      go = 1'b1;
      @(negedge clk);
      checkOutput("pulse_ir_en", 32'(ir_en), 32'd1);
      repeat (2) @(negedge clk);
      applyStimulus(1'b0, 1'b0, 20);
      checkOutput("pulse_strt_cnt", 32'(strt_n), 32'd33);
      checkOutput("pulse_ir_en_off", 32'(ir_en), 32'd0);

      // Pulse-width bookkeeping over the whole run
      checkOutput("strt_width", 32'(strt_dbl), 32'd0);
      checkOutput("wr_width",   32'(wr_dbl), 32'd0);
      checkOutput("sd_orphan",  32'(sd_orphan), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
